// File: rtl/renode_apb3_memory_completer_if.sv
// APB3 bus bundle between the Renode requester (master) and the memory completer (slave).
`timescale 1ns/1ps
interface renode_apb3_memory_completer_if #(
  parameter int AddressWidth = 20,
  parameter int DataWidth    = 32
);
  logic [AddressWidth-1:0] paddr;
  logic                    pselx;
  logic                    penable;
  logic                    pwrite;
  logic [DataWidth-1:0]    pwdata;
  logic                    pready;
  logic [DataWidth-1:0]    prdata;
  logic                    pslverr;

  modport master (
    output paddr, pselx, penable, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pselx, penable, pwrite, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/renode_apb3_memory_completer.sv
// APB3 memory completer: word memory, programmable wait states, PSLVERR on bad addresses.
// Optional sticky protocol checker under macro APB3_COMPLETER_PROTOCOL_CHECK_EN.
`timescale 1ns/1ps
module renode_apb3_memory_completer #(
  parameter int AddressWidth = 20,
  parameter int DataWidth    = 32,
  parameter int MemDepth     = 256
) (
  input  logic                                pclk,
  input  logic                                presetn,
  input  logic [3:0]                          wait_cycles,
  output logic                                protocol_error,
  renode_apb3_memory_completer_if.slave       apb
);

  localparam int B = $clog2(DataWidth / 8);
  localparam int I = $clog2(MemDepth);
  localparam logic [AddressWidth-1:0] LowMask = AddressWidth'((1 << B) - 1);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [I-1:0]           r_idx;
  logic                   r_pwrite;
  logic [DataWidth-1:0]   r_pwdata;
  logic [DataWidth-1:0]   r_rdata;
  logic                   r_err;
  logic [3:0]             r_cnt;
  logic [DataWidth-1:0]   r_mem [MemDepth];

  logic [I-1:0]           w_idx;
  logic                   w_err;
  logic                   w_setup;
  logic                   w_cnt_dec;
  logic                   w_mem_we;
  logic                   w_pready;

  // Bits above the word index being nonzero is the same as (paddr >> B) >= MemDepth.
  assign w_idx = apb.paddr[B +: I];
  assign w_err = ((apb.paddr >> (B + I)) != '0) || ((apb.paddr & LowMask) != '0);

  assign w_pready    = (r_state == S_ACCESS) && (r_cnt == 4'd0);
  assign apb.pready  = w_pready;
  assign apb.prdata  = (w_pready && !r_pwrite) ? r_rdata : '0;
  assign apb.pslverr = w_pready && r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_setup     = 1'b0;
    w_cnt_dec   = 1'b0;
    w_mem_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (apb.pselx && !apb.penable) begin
          w_setup     = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!apb.pselx) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt != 4'd0) begin
          w_cnt_dec = 1'b1;
        end else if (apb.penable) begin
          w_mem_we    = r_pwrite && !r_err;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_setup) begin
        r_idx    <= w_idx;
        r_pwrite <= apb.pwrite;
        r_pwdata <= apb.pwdata;
        r_err    <= w_err;
        r_cnt    <= wait_cycles;
        r_rdata  <= w_err ? '0 : r_mem[w_idx];
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Memory contents survive reset; only the control path is reset.
  always_ff @(posedge pclk) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_pwdata;
    end
  end

`ifdef APB3_COMPLETER_PROTOCOL_CHECK_EN
  logic [AddressWidth-1:0] r_addr;
  logic                    r_protocol_error;
  logic                    w_viol;

  always_comb begin
    w_viol = 1'b0;
    if (r_state == S_IDLE && apb.pselx && apb.penable) begin
      w_viol = 1'b1;
    end
    if (r_state == S_ACCESS && apb.pselx &&
        (apb.paddr != r_addr || apb.pwrite != r_pwrite || apb.pwdata != r_pwdata)) begin
      w_viol = 1'b1;
    end
    if (r_state == S_ACCESS && !apb.pselx && !w_pready) begin
      w_viol = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_addr           <= '0;
      r_protocol_error <= 1'b0;
    end else begin
      if (w_setup) begin
        r_addr <= apb.paddr;
      end
      if (w_viol) begin
        r_protocol_error <= 1'b1;
        $error("APB3 protocol violation at paddr=%h", apb.paddr);
      end
    end
  end

  assign protocol_error = r_protocol_error;
`else
  assign protocol_error = 1'b0;
`endif

endmodule
